// File: rtl/csi2_axis_pkg.sv
// Shared types and defaults for the CSI-2 pixel to AXI4-Stream bridge.
// Holds the bridge FSM state type, the default geometry, the derived beat
// width / beats-per-line constants and the FIFO entry side-band layout.
package csi2_axis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

  localparam int unsigned DEF_DATAWIDTH     = 10;
  localparam int unsigned DEF_NUM_OF_PIXELS = 4;
  localparam int unsigned DEF_H_RES         = 1920;
  localparam int unsigned DEF_V_RES         = 1080;
  localparam int unsigned DEF_FIFO_DEPTH    = 16;

  localparam int unsigned W       = DEF_DATAWIDTH * DEF_NUM_OF_PIXELS;
  localparam int unsigned BEATS   = DEF_H_RES / DEF_NUM_OF_PIXELS;
  localparam int unsigned FIFO_AW = $clog2(DEF_FIFO_DEPTH);

  // Side-band bits stored above the pixel data in every FIFO entry,
  // giving an entry layout of {tuser, tlast, data}.
  typedef struct packed {
    logic tuser;
    logic tlast;
  } entry_tag_t;

  function automatic int unsigned beats_per_line(int unsigned h_res, int unsigned npix);
    return h_res / npix;
  endfunction

endpackage

// File: rtl/csi2_axis_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head entry is visible on data_o whenever empty_o is low, so a word
// pushed in cycle N is readable in cycle N+1. Push and pop in the same
// cycle are both accepted even when full; a push into a full FIFO without
// a pop is ignored.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write request and entry
//   pop_i           remove the head entry (ignored when empty)
//   data_o          head entry
//   empty_o, full_o level flags
module csi2_axis_fifo #(
  parameter int unsigned g_WIDTH = 42,
  parameter int unsigned g_DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [g_WIDTH-1:0] data_i,
  input  logic               pop_i,
  output logic [g_WIDTH-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int unsigned AW = $clog2(g_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = g_DEPTH[AW:0];

  logic [g_WIDTH-1:0] mem_q [g_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        level_q;
  logic               do_push;
  logic               do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LEVEL);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage, pointers and fill level; pointers wrap naturally (depth is a power of 2).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(g_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/csi2_pixel_to_axis.sv
// CSI-2 decoder pixel output to AXI4-Stream video master.
// Captures 4-pixel beats while frame and line are valid, delays each beat
// by one in a hold register so the last beat of a line can be tagged with
// TLAST, and buffers beats in a FIFO because the decoder cannot be stalled.
// An overflow drops the rest of the frame until the next frame start.
// Line length and line count are checked and reported on frame_err_o.
// Ports:
//   PARALLEL_CLOCK_I, RESET_n_I            clock, asynchronous active-low reset
//   data_in_i, frame_start_i, frame_end_i,
//   frame_valid_i, line_valid_i            decoder side
//   m_axis_tdata_o/tvalid_o/tready_i/
//   tuser_o/tlast_o                        AXI4-Stream master (TUSER=SOF, TLAST=EOL)
//   overflow_o                             sticky, cleared by the next frame start
//   frame_err_o                            1-cycle geometry error pulse
//   line_count_o                           lines completed in the current frame
module csi2_pixel_to_axis
  import csi2_axis_pkg::*;
#(
  parameter int unsigned g_DATAWIDTH     = 10,
  parameter int unsigned g_NUM_OF_PIXELS = 4,
  parameter int unsigned g_H_RES         = 1920,
  parameter int unsigned g_V_RES         = 1080,
  parameter int unsigned g_FIFO_DEPTH    = 16
) (
  input  logic                                   PARALLEL_CLOCK_I,
  input  logic                                   RESET_n_I,
  input  logic [g_DATAWIDTH*g_NUM_OF_PIXELS-1:0] data_in_i,
  input  logic                                   frame_start_i,
  input  logic                                   frame_end_i,
  input  logic                                   frame_valid_i,
  input  logic                                   line_valid_i,
  output logic [g_DATAWIDTH*g_NUM_OF_PIXELS-1:0] m_axis_tdata_o,
  output logic                                   m_axis_tvalid_o,
  input  logic                                   m_axis_tready_i,
  output logic                                   m_axis_tuser_o,
  output logic                                   m_axis_tlast_o,
  output logic                                   overflow_o,
  output logic                                   frame_err_o,
  output logic [15:0]                            line_count_o
);

  localparam int unsigned BEAT_W       = g_DATAWIDTH * g_NUM_OF_PIXELS;
  localparam logic [15:0] LINE_BEATS_C = 16'(beats_per_line(g_H_RES, g_NUM_OF_PIXELS));
  localparam logic [15:0] BEAT_SAT_C   = LINE_BEATS_C + 16'd1;
  localparam logic [15:0] V_RES_C      = 16'(g_V_RES);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_vld_q, hold_vld_d;
  logic                hold_user_q, hold_user_d;
  logic                first_q, first_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic [15:0]         line_cnt_q, line_cnt_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic                beat;
  logic                push;
  logic                pop;
  entry_tag_t          push_tag;
  entry_tag_t          out_tag;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BEAT_W+1:0]   fifo_dout;

  assign pop = !fifo_empty && m_axis_tready_i;

  // Next-state logic: hold-register forwarding, counters, checks and FSM.
  always_comb begin
    state_d        = state_q;
    hold_data_d    = hold_data_q;
    hold_vld_d     = hold_vld_q;
    hold_user_d    = hold_user_q;
    first_d        = first_q;
    beat_cnt_d     = beat_cnt_q;
    line_cnt_d     = line_cnt_q;
    ovf_d          = ovf_q;
    err_d          = 1'b0;
    push           = 1'b0;
    push_tag.tuser = hold_user_q;
    push_tag.tlast = 1'b0;

    // A frame start opens capture in the same cycle, so its beat is taken.
    beat = ((state_q == ACTIVE) || frame_start_i) && line_valid_i && frame_valid_i;

    // The held beat leaves whenever something happens after it; it closes
    // the line unless the same line continues with a new beat.
    if (hold_vld_q) begin
      push           = 1'b1;
      push_tag.tlast = !beat || frame_start_i;
    end

    if (push && push_tag.tlast) begin
      beat_cnt_d = '0;
      line_cnt_d = line_cnt_q + 16'd1;
      if (beat_cnt_q != LINE_BEATS_C) begin
        err_d = 1'b1;
      end
    end

    if (frame_start_i) begin
      if (state_q == ACTIVE) begin
        err_d = 1'b1;
      end
      state_d    = ACTIVE;
      ovf_d      = 1'b0;
      first_d    = 1'b1;
      beat_cnt_d = '0;
      line_cnt_d = '0;
    end else if ((state_q == ACTIVE) && frame_end_i) begin
      // line_cnt_d already includes a line closed in this same cycle.
      if (line_cnt_d != V_RES_C) begin
        err_d = 1'b1;
      end
      line_cnt_d = '0;
      state_d    = IDLE;
    end

    if (beat) begin
      hold_data_d = data_in_i;
      hold_vld_d  = 1'b1;
      hold_user_d = first_d;
      first_d     = 1'b0;
      if (beat_cnt_d != BEAT_SAT_C) begin
        beat_cnt_d = beat_cnt_d + 16'd1;
      end
    end else if (push) begin
      hold_vld_d = 1'b0;
    end

    // The FIFO discards this push; give up on the rest of the frame.
    if (push && fifo_full && !pop) begin
      ovf_d      = 1'b1;
      state_d    = DROP;
      hold_vld_d = 1'b0;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge PARALLEL_CLOCK_I or negedge RESET_n_I) begin
    if (!RESET_n_I) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_vld_q  <= 1'b0;
      hold_user_q <= 1'b0;
      first_q     <= 1'b0;
      beat_cnt_q  <= '0;
      line_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
      hold_user_q <= hold_user_d;
      first_q     <= first_d;
      beat_cnt_q  <= beat_cnt_d;
      line_cnt_q  <= line_cnt_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  csi2_axis_fifo #(
    .g_WIDTH (BEAT_W + 2),
    .g_DEPTH (g_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (PARALLEL_CLOCK_I),
    .rst_ni  (RESET_n_I),
    .push_i  (push),
    .data_i  ({push_tag, hold_data_q}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign out_tag         = fifo_dout[BEAT_W +: 2];
  assign m_axis_tdata_o  = fifo_dout[BEAT_W-1:0];
  assign m_axis_tuser_o  = out_tag.tuser;
  assign m_axis_tlast_o  = out_tag.tlast;
  assign m_axis_tvalid_o = !fifo_empty;
  assign overflow_o      = ovf_q;
  assign frame_err_o     = err_q;
  assign line_count_o    = line_cnt_q;

endmodule

// File: tb/tb_csi2_pixel_to_axis.sv
// Directed testbench for csi2_pixel_to_axis with a 16x4 frame
// (4 beats per line) and an 8-entry FIFO.
module tb_csi2_pixel_to_axis;

  localparam int W = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  data_in;
  logic          fs, fe, fv, lv, tready;
  logic [W-1:0]  tdata;
  logic          tvalid, tuser, tlast, overflow, ferr;
  logic [15:0]   lcount;

  int compared   = 0;
  int mismatched = 0;
  int next_k     = 0;
  int err_seen   = 0;

  logic [W-1:0] qd[$];
  logic         qu[$];
  logic         ql[$];

  always #5 clk = ~clk;

  csi2_pixel_to_axis #(
    .g_DATAWIDTH     (10),
    .g_NUM_OF_PIXELS (4),
    .g_H_RES         (16),
    .g_V_RES         (4),
    .g_FIFO_DEPTH    (8)
  ) dut (
    .PARALLEL_CLOCK_I (clk),
    .RESET_n_I        (rst_n),
    .data_in_i        (data_in),
    .frame_start_i    (fs),
    .frame_end_i      (fe),
    .frame_valid_i    (fv),
    .line_valid_i     (lv),
    .m_axis_tdata_o   (tdata),
    .m_axis_tvalid_o  (tvalid),
    .m_axis_tready_i  (tready),
    .m_axis_tuser_o   (tuser),
    .m_axis_tlast_o   (tlast),
    .overflow_o       (overflow),
    .frame_err_o      (ferr),
    .line_count_o     (lcount)
  );

  // Record every AXI transfer and every error pulse, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid && tready) begin
        qd.push_back(tdata);
        qu.push_back(tuser);
        ql.push_back(tlast);
      end
      if (ferr) err_seen++;
    end
  end

  function automatic logic [W-1:0] mkdata(int k);
    logic [9:0] p;
    p = 10'(k * 5 + 1);
    return {p + 10'd3, p + 10'd2, p + 10'd1, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(int n);
    for (int i = 0; i < n; i++) begin
      lv = 1'b1;
      data_in = mkdata(next_k);
      next_k++;
      tick();
    end
  endtask

  task automatic send_line(int n);
    send_beats(n);
    lv = 1'b0;
    data_in = '0;
    tick();
    tick();
  endtask

  task automatic send_start();
    fv = 1'b1;
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic send_end();
    fe = 1'b1;
    tick();
    fe = 1'b0;
    fv = 1'b0;
    tick();
  endtask

  task automatic wait_out(int target, int budget);
    int c;
    c = 0;
    while (qd.size() < target && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fs = 0; fe = 0; fv = 0; lv = 0; tready = 1'b1; data_in = '0;
    repeat (3) tick();
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_tvalid: got %b expected 0", tvalid); end
    compared++; if (tdata !== '0) begin mismatched++; $display("[TB] FAIL rst_tdata: got %h expected 0", tdata); end
    compared++; if ({tuser, tlast} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_tuser_tlast: got %b expected 00", {tuser, tlast}); end
    compared++; if ({overflow, ferr} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_ovf_err: got %b expected 00", {overflow, ferr}); end
    compared++; if (lcount !== 16'd0) begin mismatched++; $display("[TB] FAIL rst_lcount: got %0d expected 0", lcount); end
    rst_n = 1'b1;
    tick();
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_after_tvalid: got %b expected 0", tvalid); end
  endtask

  task automatic test_clean_frame();
    int base, kb, eb;
    base = qd.size(); kb = next_k; eb = err_seen;
    send_start();
    for (int l = 0; l < 4; l++) send_line(4);
    compared++; if (lcount !== 16'd4) begin mismatched++; $display("[TB] FAIL t1_lcount: got %0d expected 4", lcount); end
    send_end();
    wait_out(base + 16, 100);
    compared++; if (qd.size() - base !== 16) begin mismatched++; $display("[TB] FAIL t1_count: got %0d expected 16", qd.size() - base); end
    for (int i = 0; i < 16 && base + i < qd.size(); i++) begin
      compared++; if (qd[base+i] !== mkdata(kb + i)) begin mismatched++; $display("[TB] FAIL t1_data[%0d]: got %h expected %h", i, qd[base+i], mkdata(kb + i)); end
      compared++; if (qu[base+i] !== (i == 0)) begin mismatched++; $display("[TB] FAIL t1_tuser[%0d]: got %b expected %b", i, qu[base+i], (i == 0)); end
      compared++; if (ql[base+i] !== (i % 4 == 3)) begin mismatched++; $display("[TB] FAIL t1_tlast[%0d]: got %b expected %b", i, ql[base+i], (i % 4 == 3)); end
    end
    compared++; if (err_seen - eb !== 0) begin mismatched++; $display("[TB] FAIL t1_err: got %0d pulses expected 0", err_seen - eb); end
    compared++; if (lcount !== 16'd0) begin mismatched++; $display("[TB] FAIL t1_lcount_clear: got %0d expected 0", lcount); end
  endtask

  task automatic test_backpressure();
    int base, kb;
    base = qd.size(); kb = next_k;
    fork
      begin
        send_start();
        for (int l = 0; l < 4; l++) send_line(4);
        send_end();
      end
      begin
        repeat (3) tick();
        tready = 1'b0;
        repeat (6) tick();
        tready = 1'b1;
      end
    join
    wait_out(base + 16, 100);
    compared++; if (qd.size() - base !== 16) begin mismatched++; $display("[TB] FAIL t2_count: got %0d expected 16", qd.size() - base); end
    for (int i = 0; i < 16 && base + i < qd.size(); i++) begin
      compared++; if (qd[base+i] !== mkdata(kb + i)) begin mismatched++; $display("[TB] FAIL t2_data[%0d]: got %h expected %h", i, qd[base+i], mkdata(kb + i)); end
      compared++; if (ql[base+i] !== (i % 4 == 3)) begin mismatched++; $display("[TB] FAIL t2_tlast[%0d]: got %b expected %b", i, ql[base+i], (i % 4 == 3)); end
    end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL t2_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    int base, kb;
    tready = 1'b0;
    base = qd.size(); kb = next_k;
    send_start();
    for (int l = 0; l < 4; l++) send_line(4);
    send_end();
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL t3_overflow_set: got %b expected 1", overflow); end
    compared++; if (qd.size() - base !== 0) begin mismatched++; $display("[TB] FAIL t3_stalled: got %0d expected 0", qd.size() - base); end
    tready = 1'b1;
    repeat (30) tick();
    compared++; if (qd.size() - base !== 8) begin mismatched++; $display("[TB] FAIL t3_drain_count: got %0d expected 8", qd.size() - base); end
    for (int i = 0; i < 8 && base + i < qd.size(); i++) begin
      compared++; if (qd[base+i] !== mkdata(kb + i)) begin mismatched++; $display("[TB] FAIL t3_data[%0d]: got %h expected %h", i, qd[base+i], mkdata(kb + i)); end
      compared++; if ({qu[base+i], ql[base+i]} !== {(i == 0), (i % 4 == 3)}) begin mismatched++; $display("[TB] FAIL t3_flags[%0d]: got %b expected %b", i, {qu[base+i], ql[base+i]}, {(i == 0), (i % 4 == 3)}); end
    end
    base = qd.size(); kb = next_k;
    send_start();
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL t3_overflow_clear: got %b expected 0", overflow); end
    for (int l = 0; l < 4; l++) send_line(4);
    send_end();
    wait_out(base + 16, 100);
    compared++; if (qd.size() - base !== 16) begin mismatched++; $display("[TB] FAIL t3_next_count: got %0d expected 16", qd.size() - base); end
    for (int i = 0; i < 16 && base + i < qd.size(); i++) begin
      compared++; if (qd[base+i] !== mkdata(kb + i)) begin mismatched++; $display("[TB] FAIL t3_next_data[%0d]: got %h expected %h", i, qd[base+i], mkdata(kb + i)); end
      compared++; if ({qu[base+i], ql[base+i]} !== {(i == 0), (i % 4 == 3)}) begin mismatched++; $display("[TB] FAIL t3_next_flags[%0d]: got %b expected %b", i, {qu[base+i], ql[base+i]}, {(i == 0), (i % 4 == 3)}); end
    end
  endtask

  task automatic test_geometry();
    int base, eb;
    base = qd.size(); eb = err_seen;
    send_start();
    send_line(4); send_line(3); send_line(4); send_line(4);
    compared++; if (err_seen - eb !== 1) begin mismatched++; $display("[TB] FAIL t4_short_err: got %0d pulses expected 1", err_seen - eb); end
    send_end();
    wait_out(base + 15, 100);
    compared++; if (qd.size() - base !== 15) begin mismatched++; $display("[TB] FAIL t4_count: got %0d expected 15", qd.size() - base); end
    for (int i = 0; i < 15 && base + i < qd.size(); i++) begin
      compared++; if (ql[base+i] !== (i == 3 || i == 6 || i == 10 || i == 14)) begin mismatched++; $display("[TB] FAIL t4_tlast[%0d]: got %b expected %b", i, ql[base+i], (i == 3 || i == 6 || i == 10 || i == 14)); end
    end
    compared++; if (err_seen - eb !== 1) begin mismatched++; $display("[TB] FAIL t4_frame_a_err: got %0d pulses expected 1", err_seen - eb); end
    base = qd.size(); eb = err_seen;
    send_start();
    for (int l = 0; l < 3; l++) send_line(4);
    compared++; if (err_seen - eb !== 0) begin mismatched++; $display("[TB] FAIL t4_early_err: got %0d pulses expected 0", err_seen - eb); end
    send_end();
    wait_out(base + 12, 100);
    compared++; if (err_seen - eb !== 1) begin mismatched++; $display("[TB] FAIL t4_lines_err: got %0d pulses expected 1", err_seen - eb); end
    compared++; if (qd.size() - base !== 12) begin mismatched++; $display("[TB] FAIL t4_b_count: got %0d expected 12", qd.size() - base); end
  endtask

  task automatic test_start_cases();
    int base, kb, eb;
    base = qd.size(); kb = next_k; eb = err_seen;
    fv = 1'b1; fs = 1'b1;
    send_beats(1);
    fs = 1'b0;
    send_line(3);
    for (int l = 0; l < 3; l++) send_line(4);
    send_end();
    wait_out(base + 16, 100);
    compared++; if (qd.size() - base !== 16) begin mismatched++; $display("[TB] FAIL t5a_count: got %0d expected 16", qd.size() - base); end
    for (int i = 0; i < 16 && base + i < qd.size(); i++) begin
      compared++; if ({qu[base+i], ql[base+i]} !== {(i == 0), (i % 4 == 3)}) begin mismatched++; $display("[TB] FAIL t5a_flags[%0d]: got %b expected %b", i, {qu[base+i], ql[base+i]}, {(i == 0), (i % 4 == 3)}); end
    end
    compared++; if (err_seen - eb !== 0) begin mismatched++; $display("[TB] FAIL t5a_err: got %0d pulses expected 0", err_seen - eb); end

    base = qd.size(); kb = next_k; eb = err_seen;
    send_start();
    send_line(4);
    send_beats(2);
    compared++; if (lcount !== 16'd1) begin mismatched++; $display("[TB] FAIL t5b_lcount_before: got %0d expected 1", lcount); end
    lv = 1'b0; data_in = '0; fs = 1'b1;
    tick();
    fs = 1'b0;
    compared++; if (lcount !== 16'd0) begin mismatched++; $display("[TB] FAIL t5b_lcount_cleared: got %0d expected 0", lcount); end
    tick();
    for (int l = 0; l < 4; l++) send_line(4);
    compared++; if (lcount !== 16'd4) begin mismatched++; $display("[TB] FAIL t5b_lcount_end: got %0d expected 4", lcount); end
    send_end();
    wait_out(base + 22, 100);
    compared++; if (qd.size() - base !== 22) begin mismatched++; $display("[TB] FAIL t5b_count: got %0d expected 22", qd.size() - base); end
    for (int i = 0; i < 22 && base + i < qd.size(); i++) begin
      compared++; if (qd[base+i] !== mkdata(kb + i)) begin mismatched++; $display("[TB] FAIL t5b_data[%0d]: got %h expected %h", i, qd[base+i], mkdata(kb + i)); end
      compared++; if ({qu[base+i], ql[base+i]} !== {(i == 0 || i == 6), (i == 3 || i == 5 || (i >= 6 && (i - 6) % 4 == 3))}) begin
        mismatched++; $display("[TB] FAIL t5b_flags[%0d]: got %b expected %b", i, {qu[base+i], ql[base+i]}, {(i == 0 || i == 6), (i == 3 || i == 5 || (i >= 6 && (i - 6) % 4 == 3))});
      end
    end
    compared++; if (err_seen - eb !== 1) begin mismatched++; $display("[TB] FAIL t5b_err: got %0d pulses expected 1", err_seen - eb); end
  endtask

  task automatic test_reset_midline();
    int base, kb;
    tready = 1'b0;
    send_start();
    send_line(4);
    send_beats(2);
    compared++; if (tvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL t6_filled: got %b expected 1", tvalid); end
    rst_n = 1'b0;
    #1;
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL t6_tvalid: got %b expected 0", tvalid); end
    compared++; if ({tdata, tuser, tlast} !== '0) begin mismatched++; $display("[TB] FAIL t6_outputs: got %h expected 0", {tdata, tuser, tlast}); end
    compared++; if ({overflow, ferr, lcount} !== '0) begin mismatched++; $display("[TB] FAIL t6_status: got %h expected 0", {overflow, ferr, lcount}); end
    tick(); tick();
    rst_n = 1'b1;
    tready = 1'b1;
    base = qd.size();
    send_line(2);
    send_line(4);
    fv = 1'b0;
    repeat (20) tick();
    compared++; if (qd.size() - base !== 0) begin mismatched++; $display("[TB] FAIL t6_silent: got %0d beats expected 0", qd.size() - base); end
    base = qd.size(); kb = next_k;
    send_start();
    for (int l = 0; l < 4; l++) send_line(4);
    send_end();
    wait_out(base + 16, 100);
    compared++; if (qd.size() - base !== 16) begin mismatched++; $display("[TB] FAIL t6_count: got %0d expected 16", qd.size() - base); end
    for (int i = 0; i < 16 && base + i < qd.size(); i++) begin
      compared++; if (qd[base+i] !== mkdata(kb + i)) begin mismatched++; $display("[TB] FAIL t6_data[%0d]: got %h expected %h", i, qd[base+i], mkdata(kb + i)); end
      compared++; if (qu[base+i] !== (i == 0)) begin mismatched++; $display("[TB] FAIL t6_tuser[%0d]: got %b expected %b", i, qu[base+i], (i == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_overflow();
    test_geometry();
    test_start_cases();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
